mult_seq: RTL and testbench

Parametrised sequential shift-add multiplier. It multiplies two WIDTH-bit operands over WIDTH clock cycles and returns a 2*WIDTH-bit product through a start/done handshake. It replaces the fixed 3-bit combinational multiplier in datapaths where operand width must scale and area matters more than single-cycle latency. One multiplication is in flight at a time.

---
 rtl/mult_seq_if.sv | 14 +
 rtl/mult_seq.sv | 95 +++++++++
 tb/tb_mult_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - start/done handshake bundle for the sequential multiplier
interface mult_seq_if #(
  parameter int WIDTH = 8
) ();
  logic               start;
  logic [WIDTH-1:0]   num1;
  logic [WIDTH-1:0]   num2;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (output start, num1, num2, input busy, done, result);
  modport slave  (input start, num1, num2, output busy, done, result);
endinterface

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - WIDTH-cycle shift-add multiplier with start/done handshake
// Define MULT_SIGNED_EN for two's complement operands and result.
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  mult_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               last;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_shift;

  // prod_q holds {accumulator, remaining multiplier bits}; one bit retires per RUN edge
  always_comb begin
    last = (count_q == CW'(WIDTH - 1));
`ifdef MULT_SIGNED_EN
    sum = {prod_q[2*WIDTH-1], prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) begin
      // multiplier MSB carries negative weight, so the last partial product is subtracted
      if (last)
        sum = sum - {mcand_q[WIDTH-1], mcand_q};
      else
        sum = sum + {mcand_q[WIDTH-1], mcand_q};
    end
`else
    sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0])
      sum = sum + {1'b0, mcand_q};
`endif
    prod_shift = {sum, prod_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          mcand_d = bus.num1;
          prod_d  = {{WIDTH{1'b0}}, bus.num2};
          count_d = '0;
        end
      end
      RUN: begin
        prod_d = prod_shift;
        if (last) begin
          state_d  = DONE;
          result_d = prod_shift;
          count_d  = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      prod_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq at WIDTH 3 and 8
module tb_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(3)) if3 ();
  mult_seq_if #(.WIDTH(8)) if8 ();

  mult_seq #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  mult_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  // Reference product truncated to 2*w bits, by plain arithmetic
  function automatic logic [63:0] ref_mul(int w, logic [31:0] a, logic [31:0] b);
    logic [63:0] mask;
    logic [63:0] p;
`ifdef MULT_SIGNED_EN
    longint sa;
    longint sb;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    p  = 64'(sa * sb);
`else
    p = {32'b0, a} * {32'b0, b};
`endif
    mask = (64'd1 << (2 * w)) - 64'd1;
    return p & mask;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single operation on the 8-bit unit, caller positioned 1ns after an edge with unit idle
  task automatic op8(logic [7:0] a, logic [7:0] b, logic [15:0] exp, string tag);
    if8.num1  = a;
    if8.num2  = b;
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.num1  = 8'($urandom);
    if8.num2  = 8'($urandom);
    chk({tag, " busy@0"}, 64'(if8.busy), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk({tag, " done"}, 64'(if8.done), (k == 8) ? 64'd1 : 64'd0);
      chk({tag, " busy"}, 64'(if8.busy), 64'd1);
    end
    chk({tag, " result"}, 64'(if8.result), 64'(exp));
    @(posedge clk); #1;
    chk({tag, " done end"}, 64'(if8.done), 64'd0);
    chk({tag, " busy end"}, 64'(if8.busy), 64'd0);
    chk({tag, " result hold"}, 64'(if8.result), 64'(exp));
  endtask

  initial begin
    int dones;
    logic [7:0] ra;
    logic [7:0] rb;

    if3.start = 1'b0; if3.num1 = '0; if3.num2 = '0;
    if8.start = 1'b0; if8.num1 = '0; if8.num2 = '0;

    // reset and idle
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst busy8", 64'(if8.busy), 64'd0);
      chk("rst result8", 64'(if8.result), 64'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle busy8", 64'(if8.busy), 64'd0);
      chk("idle done8", 64'(if8.done), 64'd0);
      chk("idle result8", 64'(if8.result), 64'd0);
      chk("idle busy3", 64'(if3.busy), 64'd0);
      chk("idle done3", 64'(if3.done), 64'd0);
      chk("idle result3", 64'(if3.result), 64'd0);
    end

    // WIDTH=3 exhaustive with start held high
    if3.start = 1'b1;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        if3.num1 = 3'(a);
        if3.num2 = 3'(b);
        @(posedge clk); #1;
        chk("w3 busy@0", 64'(if3.busy), 64'd1);
        for (int k = 1; k <= 3; k++) begin
          @(posedge clk); #1;
          chk("w3 done", 64'(if3.done), (k == 3) ? 64'd1 : 64'd0);
        end
        chk("w3 result", 64'(if3.result), ref_mul(3, 32'(a), 32'(b)));
        @(posedge clk); #1;
        chk("w3 busy idle", 64'(if3.busy), 64'd0);
        chk("w3 done idle", 64'(if3.done), 64'd0);
      end
    end
    if3.start = 1'b0;

    // WIDTH=8 directed corners and random operands
`ifdef MULT_SIGNED_EN
    op8(8'hFD, 8'd5,  16'hFFF1, "s -3*5");
    op8(8'h80, 8'h80, 16'h4000, "s -128*-128");
    op8(8'h7F, 8'h80, 16'hC080, "s 127*-128");
    op8(8'hFF, 8'hFF, 16'h0001, "s -1*-1");
`else
    op8(8'd255, 8'd255, 16'hFE01, "u 255*255");
    op8(8'd0,   8'd255, 16'h0000, "u 0*255");
`endif
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8(ra, rb, 16'(ref_mul(8, 32'(ra), 32'(rb))), "rand");
    end

    // start and operand changes while busy
    dones = 0;
    if8.num1 = 8'd12; if8.num2 = 8'd10; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (if8.done) dones++;
      if (c >= 2 && c <= 7) begin
        if8.start = (c % 2 == 0);
        if8.num1  = 8'($urandom);
        if8.num2  = 8'($urandom);
      end else begin
        if8.start = 1'b0;
      end
    end
    chk("busy-ignore result", 64'(if8.result), ref_mul(8, 32'd12, 32'd10));
    chk("busy-ignore dones", 64'(dones), 64'd1);
    chk("busy-ignore idle", 64'(if8.busy), 64'd0);

    // reset mid-operation
    if8.num1 = 8'd200; if8.num2 = 8'd3; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", 64'(if8.busy), 64'd0);
    chk("midrst done", 64'(if8.done), 64'd0);
    chk("midrst result", 64'(if8.result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (if8.done) dones++;
    end
    chk("midrst no done", 64'(dones), 64'd0);
    chk("midrst result stays", 64'(if8.result), 64'd0);
    op8(8'd2, 8'd3, 16'd6, "after rst 2*3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
